// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiply sequencer for the EX-stage MUL path; stalls the front end until the product is ready.
// Optional early termination when the remaining multiplier bits are zero: define MUL_EARLY_TERM_EN.
module mul_seq_ctrl #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      src_a,
    input  logic [WIDTH-1:0]      src_b,
    input  logic [REG_ADDR_W-1:0] dest_in,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic [REG_ADDR_W-1:0] dest_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   a_reg_r;
    logic [WIDTH-1:0]   b_reg_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   acc_next_s;
    logic [WIDTH-1:0]   b_shift_s;
    logic               last_s;
    logic               launch_s;

    // Per-iteration datapath values and the terminating condition for RUN
    always_comb begin
        acc_next_s = acc_r;
        if (b_reg_r[0]) begin
            acc_next_s = acc_r + a_reg_r;
        end else begin
            acc_next_s = acc_r;
        end
        b_shift_s = b_reg_r >> 1;
        last_s    = (cnt_r == CNT_W'(1)) || (EARLY_TERM && (b_shift_s == {WIDTH{1'b0}}));
        launch_s  = start & ~flush;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
        if (flush) begin
            next_state_s = IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // Stall output: start in DONE belongs to the finishing MUL, so it does not stall
    always_comb begin
        stall = 1'b0;
        if (reset || flush) begin
            stall = 1'b0;
        end else begin
            case (state_r)
                IDLE:    stall = start;
                RUN:     stall = 1'b1;
                DONE:    stall = 1'b0;
                default: stall = 1'b0;
            endcase
        end
    end

    // Operand latch, shift-add iteration, result capture and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r    <= {WIDTH{1'b0}};
            a_reg_r  <= {WIDTH{1'b0}};
            b_reg_r  <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            result   <= {WIDTH{1'b0}};
            dest_out <= {REG_ADDR_W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (next_state_s != IDLE);
            done <= (next_state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        a_reg_r  <= src_a;
                        b_reg_r  <= src_b;
                        dest_out <= dest_in;
                        acc_r    <= {WIDTH{1'b0}};
                        cnt_r    <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    if (!flush) begin
                        acc_r   <= acc_next_s;
                        a_reg_r <= a_reg_r << 1;
                        b_reg_r <= b_shift_s;
                        cnt_r   <= cnt_r - CNT_W'(1);
                        if (last_s) begin
                            result <= acc_next_s;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: randomized and directed MULs against a plain-arithmetic reference.
// Expected latency follows MUL_EARLY_TERM_EN when the bench is built with that macro.
module tb_mul_seq_ctrl;

    localparam int W = 32;
    localparam int RW = 5;

`ifdef MUL_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          flush;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [RW-1:0] dest_in;
    logic          stall;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [RW-1:0] dest_out;

    int checks;
    int failures;

    mul_seq_ctrl #(.WIDTH(W), .REG_ADDR_W(RW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .flush    (flush),
        .src_a    (src_a),
        .src_b    (src_b),
        .dest_in  (dest_in),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .dest_out (dest_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
    endfunction

    // Number of RUN cycles the multiplier needs for this multiplier operand
    function automatic int ref_run(input logic [W-1:0] b);
        int hi;
        hi = 0;
        for (int i = 0; i < W; i++) if (b[i]) hi = i + 1;
        if (ET) return (hi == 0) ? 1 : hi;
        return W;
    endfunction

    // Launch one MUL at the next falling edge, hold start until done is seen (cycle 0 = launch cycle)
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [RW-1:0] d,
                           output int sc, output int dc, output logic [W-1:0] res,
                           output logic [RW-1:0] dst, output logic busy0);
        sc = 0; dc = -1; res = '0; dst = '0; busy0 = 1'b0;
        @(negedge clk);
        start = 1'b1; src_a = a; src_b = b; dest_in = d;
        for (int cyc = 0; cyc < 80; cyc++) begin
            #1;
            if (cyc == 0) busy0 = busy;
            if (stall) sc++;
            if (done) begin
                dc = cyc; res = result; dst = dest_out;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic end_op();
        @(negedge clk);
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; flush = 1'b0;
        src_a = 32'h1234_5678; src_b = 32'h9abc_def0; dest_in = 5'd9;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (dest_out !== 5'd0) begin failures++; $display("FAIL reset_dest got=%h exp=0", dest_out); end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL post_reset_idle busy=%b stall=%b exp=0/0", busy, stall); end
    endtask

    task automatic test_basic();
        int sc, dc; logic [W-1:0] res; logic [RW-1:0] dst; logic b0;
        run_mul(32'd6, 32'd1, 5'd7, sc, dc, res, dst, b0);
        checks++; if (dc !== ref_run(32'd1) + 1) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=%0d", dc, ref_run(32'd1) + 1); end
        checks++; if (sc !== ref_run(32'd1) + 1) begin failures++; $display("FAIL basic_stall_cycles got=%0d exp=%0d", sc, ref_run(32'd1) + 1); end
        checks++; if (res !== 32'd6) begin failures++; $display("FAIL basic_result got=%h exp=6", res); end
        checks++; if (dst !== 5'd7) begin failures++; $display("FAIL basic_dest got=%h exp=7", dst); end
        end_op();
    endtask

    task automatic test_factorial();
        int sc, dc; logic [W-1:0] res; logic [RW-1:0] dst; logic b0; logic [W-1:0] acc;
        acc = 32'd6;
        for (int k = 5; k >= 1; k--) begin
            run_mul(acc, W'(k), 5'(k), sc, dc, res, dst, b0);
            checks++; if (dc !== ref_run(W'(k)) + 1) begin failures++; $display("FAIL fact_done_cycle k=%0d got=%0d exp=%0d", k, dc, ref_run(W'(k)) + 1); end
            acc = res;
        end
        end_op();
        checks++; if (acc !== 32'h0000_02D0) begin failures++; $display("FAIL fact_result got=%h exp=000002d0", acc); end
        checks++; if (result !== 32'h0000_02D0) begin failures++; $display("FAIL fact_result_hold got=%h exp=000002d0", result); end
    endtask

    task automatic test_corners();
        int sc, dc; logic [W-1:0] res; logic [RW-1:0] dst; logic b0;
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, sc, dc, res, dst, b0);
        checks++; if (res !== 32'h0000_0001) begin failures++; $display("FAIL corner_ones got=%h exp=00000001", res); end
        checks++; if (dc !== ref_run(32'hFFFF_FFFF) + 1) begin failures++; $display("FAIL corner_ones_cycle got=%0d exp=%0d", dc, ref_run(32'hFFFF_FFFF) + 1); end
        end_op();
        run_mul(32'h8000_0000, 32'd2, 5'd1, sc, dc, res, dst, b0);
        checks++; if (res !== 32'd0) begin failures++; $display("FAIL corner_msb got=%h exp=0", res); end
        end_op();
        run_mul(32'd5, 32'd3, 5'd2, sc, dc, res, dst, b0);
        checks++; if (res !== 32'd15) begin failures++; $display("FAIL corner_5x3 got=%h exp=f", res); end
        checks++; if (dc !== ref_run(32'd3) + 1) begin failures++; $display("FAIL corner_5x3_cycle got=%0d exp=%0d", dc, ref_run(32'd3) + 1); end
        end_op();
        run_mul(32'hDEAD_BEEF, 32'd0, 5'd3, sc, dc, res, dst, b0);
        checks++; if (res !== 32'd0) begin failures++; $display("FAIL corner_bzero got=%h exp=0", res); end
        checks++; if (dc !== ref_run(32'd0) + 1) begin failures++; $display("FAIL corner_bzero_cycle got=%0d exp=%0d", dc, ref_run(32'd0) + 1); end
        end_op();
    endtask

    task automatic test_back_to_back();
        int sc, dc; logic [W-1:0] res; logic [RW-1:0] dst; logic b0;
        run_mul(32'd11, 32'd13, 5'd4, sc, dc, res, dst, b0);
        run_mul(32'd17, 32'd19, 5'd5, sc, dc, res, dst, b0);
        checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL b2b_relaunch_from_done busy=%b exp=0", b0); end
        checks++; if (dc !== ref_run(32'd19) + 1) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=%0d", dc, ref_run(32'd19) + 1); end
        checks++; if (res !== 32'd323 || dst !== 5'd5) begin failures++; $display("FAIL b2b_result got=%h/%h exp=143/05", res, dst); end
        end_op();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL b2b_single_pulse done=%b busy=%b stall=%b exp=0/0/0", done, busy, stall); end
    endtask

    task automatic test_random();
        int sc, dc; logic [W-1:0] res; logic [RW-1:0] dst; logic b0;
        logic [W-1:0] a, b; logic [RW-1:0] d;
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            d = RW'($urandom);
            run_mul(a, b, d, sc, dc, res, dst, b0);
            checks++;
            if (res !== ref_mul(a, b) || dst !== d || dc !== ref_run(b) + 1 || sc !== ref_run(b) + 1) begin
                failures++;
                $display("FAIL random_op a=%h b=%h got res=%h dst=%h dc=%0d sc=%0d exp res=%h dst=%h dc=%0d",
                         a, b, res, dst, dc, sc, ref_mul(a, b), d, ref_run(b) + 1);
            end
            if ($urandom_range(0, 1) == 0) end_op();
        end
        end_op();
    endtask

    task automatic test_flush();
        int pulses; logic [W-1:0] prev;
        prev = result;
        @(negedge clk);
        start = 1'b1; src_a = 32'd7; src_b = 32'h8000_0003; dest_in = 5'd12;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL flush_cycle stall=%b busy=%b exp=0/1", stall, busy); end
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL flush_abort busy=%b stall=%b exp=0/0", busy, stall); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", pulses); end
        checks++; if (result !== prev) begin failures++; $display("FAIL flush_result_hold got=%h exp=%h", result, prev); end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        @(negedge clk);
        start = 1'b1; src_a = 32'd9; src_b = 32'h8000_0005; dest_in = 5'd21;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%b exp=0", stall); end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || dest_out !== 5'd0) begin
            failures++; $display("FAIL rst_mid_clear busy=%b done=%b result=%h dest=%h exp=0/0/0/0", busy, done, result, dest_out);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", pulses); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        src_a = '0; src_b = '0; dest_in = '0;
        test_reset();
        test_basic();
        test_factorial();
        test_corners();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
